slave_spi_receiver: RTL and testbench
=====================================

// Module: slave_spi_receiver
// PURPOSE
// Receive side of the node-to-node serial link. Deserialises one WIDTH-bit instruction per
// chip-select frame from a neighbour's master_spi (sclk/sdi/cs) and presents it to the node's
// receiver_queue input port with a valid/ready handshake. Flags short, long and overrun frames.
// All link inputs are asynchronous to clk and are synchronised inside the block.
// PARAMETERS
// WIDTH        32  instruction width in bits; also the exact bit count of a legal frame
// CNT_BITS     6   bit-counter width; must satisfy 2**CNT_BITS > WIDTH
// PORTS
// clk          in   1      system clock
// rst_n        in   1      asynchronous active-low reset
// sclk_in      in   1      link serial clock; data is sampled on its rising edge
// sdi_in       in   1      link serial data, MSB first
// cs_in        in   1      link chip select, active high; one frame per high period
// instr_ready  in   1      receiver_queue can accept instr_out this cycle
// instr_out    out  WIDTH  last accepted instruction; held stable while instr_valid=1
// instr_valid  out  1      instr_out holds an unconsumed instruction
// frame_error  out  1      1-cycle pulse: frame closed with bit count != WIDTH
// overrun      out  1      1-cycle pulse: legal frame dropped because instr_valid still high
// busy         out  1      1 while a frame is in progress (state RECV)
// BEHAVIOUR
// - Reset (async assert, sync deassert release): instr_out=0, instr_valid=0, frame_error=0,
//   overrun=0, busy=0, shift register=0, bit count=0, state=IDLE, all sync flops=0.
// - sclk_in, sdi_in, cs_in each pass through 2 flops; a third flop on sclk and cs gives
//   registered edge detect. Link requirement: sclk high and low phases >= 3 clk periods.
// - FSM IDLE: on synced cs rise -> RECV; clear bit count and shift register.
// - FSM RECV: each synced sclk rise: shift_reg <= {shift_reg[WIDTH-2:0], sdi_sync};
//   count increments, saturating at WIDTH+1 (saturation marks over-length).
//   On synced cs fall -> IDLE and evaluate frame in the same cycle:
//     count==0         : ignored, no outputs change.
//     count==WIDTH     : legal. If instr_valid==0 or instr_ready==1: instr_out<=shift_reg,
//                        instr_valid<=1. Else drop frame, pulse overrun.
//     any other count  : pulse frame_error; instr_out/instr_valid unchanged.
//   sclk rise and cs fall in the same synced cycle: shift is applied first, then evaluate.
// - Latency: instr_valid rises 3 clk edges after the first clk edge sampling cs_in low.
// - Handshake: instr_valid & instr_ready on a clk edge consumes the word; instr_valid
//   clears next cycle unless a legal frame completes on that same edge (then reloads,
//   stays high, no overrun). instr_out never changes while instr_valid=1 and instr_ready=0.
// - cs rise while in RECV cannot occur (cs fall always seen first); sclk edges in IDLE ignored.
// - Reset mid-frame: partial frame discarded, no error pulse; next frame starts clean.
// - busy = (state==RECV); frame_error and overrun are never high in the same cycle.
// TESTING
// 1 Legal frame 0xA5C3_0F81, instr_ready=1 -> instr_valid one cycle, instr_out=0xA5C30F81,
//   valid rises 3 clk after cs_in falls; no error/overrun.
// 2 Frame of 31 bits, then 33 bits -> one frame_error pulse each; instr_valid stays 0.
// 3 Frame 0x1111_1111 with instr_ready=0, then frame 0x2222_2222 -> instr_out=0x11111111
//   held, overrun pulses once; after instr_ready=1 for one cycle, instr_valid drops to 0.
// 4 instr_ready asserted on the exact edge a second legal frame 0x3333_3333 completes ->
//   no overrun, instr_valid stays 1, instr_out=0x33333333.
// 5 rst_n pulsed low after 16 bits of a frame -> all outputs 0 immediately; following
//   full frame 0xDEAD_BEEF received correctly with no error pulse.
// 6 cs_in high/low with no sclk edges -> no output activity; busy high only during cs window.

Source files
------------

// File: rtl/slave_spi_receiver_if.sv
// Link-side and queue-side signals of the slave SPI receiver.
//   slave  modport: receiver view (link + instr_ready in, instruction and status out)
//   master modport: neighbour/queue view (drives link + instr_ready, observes outputs)
interface slave_spi_receiver_if #(
  parameter int WIDTH = 32
);
  logic             sclk_in;      // link serial clock, sampled on rising edge
  logic             sdi_in;       // link serial data, MSB first
  logic             cs_in;        // link chip select, active high
  logic             instr_ready;  // receiver_queue can take instr_out
  logic [WIDTH-1:0] instr_out;    // last accepted instruction
  logic             instr_valid;  // instr_out holds an unconsumed instruction
  logic             frame_error;  // 1-cycle pulse: bad bit count
  logic             overrun;      // 1-cycle pulse: legal frame dropped
  logic             busy;         // frame in progress

  modport slave (
    input  sclk_in, sdi_in, cs_in, instr_ready,
    output instr_out, instr_valid, frame_error, overrun, busy
  );

  modport master (
    output sclk_in, sdi_in, cs_in, instr_ready,
    input  instr_out, instr_valid, frame_error, overrun, busy
  );
endinterface

// File: rtl/slave_spi_receiver.sv
// Deserialises one WIDTH-bit instruction per chip-select frame and offers it to the queue.
// Latency: instr_valid rises 3 clk edges after the first edge that samples cs_in low.
// Backpressure: one-word holding register; a legal frame arriving while it is full and
//   instr_ready is low is dropped and flagged with an overrun pulse.
// Ports: clk, rst_n (async active-low); link = slave modport of slave_spi_receiver_if
//   (sclk_in/sdi_in/cs_in/instr_ready in; instr_out/instr_valid/frame_error/overrun/busy out).
module slave_spi_receiver #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slave_spi_receiver_if.slave  link
);

  typedef enum logic {IDLE, RECV} rxState;

  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(WIDTH + 1);

  // Synchroniser chains; stage 3 on sclk/cs feeds the registered edge detectors,
  // and sdi gets a matching third stage so data lines up with the sclk rise pulse.
  logic [2:0] sclkSync, sdiSync, csSync;
  logic       sclkRise, csRise, csFall;

  rxState               state, stateNext;
  logic [WIDTH-1:0]     shiftReg, shiftNext;
  logic [CNT_BITS-1:0]  bitCnt, cntNext;
  logic [WIDTH-1:0]     instrOut, instrOutNext;
  logic                 instrValid, instrValidNext;
  logic                 frameErr, frameErrNext;
  logic                 overrunR, overrunNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync <= '0;
      sdiSync  <= '0;
      csSync   <= '0;
      sclkRise <= 1'b0;
      csRise   <= 1'b0;
      csFall   <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[1:0], link.sclk_in};
      sdiSync  <= {sdiSync[1:0], link.sdi_in};
      csSync   <= {csSync[1:0], link.cs_in};
      sclkRise <= sclkSync[1] & ~sclkSync[2];
      csRise   <= csSync[1] & ~csSync[2];
      csFall   <= ~csSync[1] & csSync[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      instrOut   <= '0;
      instrValid <= 1'b0;
      frameErr   <= 1'b0;
      overrunR   <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftNext;
      bitCnt     <= cntNext;
      instrOut   <= instrOutNext;
      instrValid <= instrValidNext;
      frameErr   <= frameErrNext;
      overrunR   <= overrunNext;
    end
  end

  always_comb begin
    stateNext      = state;
    shiftNext      = shiftReg;
    cntNext        = bitCnt;
    instrOutNext   = instrOut;
    // A held word is consumed on any edge where the queue is ready.
    instrValidNext = instrValid & ~link.instr_ready;
    frameErrNext   = 1'b0;
    overrunNext    = 1'b0;

    case (state)
      IDLE: begin
        if (csRise) begin
          stateNext = RECV;
          shiftNext = '0;
          cntNext   = '0;
        end
      end
      RECV: begin
        if (sclkRise) begin
          shiftNext = {shiftReg[WIDTH-2:0], sdiSync[2]};
          // Saturating one past WIDTH keeps any over-length frame distinguishable.
          if (bitCnt != CNT_SAT) cntNext = bitCnt + 1'b1;
        end
        // Evaluation uses the post-shift values so a coincident last bit counts.
        if (csFall) begin
          stateNext = IDLE;
          if (cntNext == CNT_FULL) begin
            if (!instrValid || link.instr_ready) begin
              instrOutNext   = shiftNext;
              instrValidNext = 1'b1;
            end else begin
              overrunNext = 1'b1;
            end
          end else if (cntNext != '0) begin
            frameErrNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign link.instr_out   = instrOut;
  assign link.instr_valid = instrValid;
  assign link.frame_error = frameErr;
  assign link.overrun     = overrunR;
  assign link.busy        = (state == RECV);

endmodule

// File: tb/tb_slave_spi_receiver.sv
// Directed bench for slave_spi_receiver: legal, short/long, overrun, same-edge reload,
// mid-frame reset and empty-frame cases, with hand-computed expectations.
module tb_slave_spi_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int errCnt  = 0;
  int ovrCnt  = 0;
  int bothCnt = 0;

  slave_spi_receiver_if #(.WIDTH(32)) spiIf ();

  slave_spi_receiver #(.WIDTH(32), .CNT_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (spiIf.slave)
  );

  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (spiIf.frame_error) errCnt++;
    if (spiIf.overrun) ovrCnt++;
    if (spiIf.frame_error && spiIf.overrun) bothCnt++;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csOpen();
    spiIf.cs_in = 1'b1;
    waitNeg(4);
  endtask

  // Shift n bits of data, MSB (bit n-1) first; sclk low/high phases of 4 clk each.
  task automatic shiftBits(input logic [63:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spiIf.sclk_in = 1'b0;
      spiIf.sdi_in  = data[i];
      waitNeg(4);
      spiIf.sclk_in = 1'b1;
      waitNeg(4);
    end
    spiIf.sclk_in = 1'b0;
    waitNeg(4);
  endtask

  task automatic csClose();
    spiIf.cs_in = 1'b0;
    waitNeg(6);
  endtask

  task automatic sendFrame(input logic [63:0] data, input int n);
    csOpen();
    shiftBits(data, n);
    csClose();
  endtask

  initial begin
    int lat;
    logic [31:0] seenOut;

    spiIf.sclk_in     = 1'b0;
    spiIf.sdi_in      = 1'b0;
    spiIf.cs_in       = 1'b0;
    spiIf.instr_ready = 1'b0;

    // Reset state
    waitNeg(3);
    checkVal("rst_valid", spiIf.instr_valid, 0);
    checkVal("rst_out",   spiIf.instr_out,   0);
    checkVal("rst_err",   spiIf.frame_error, 0);
    checkVal("rst_ovr",   spiIf.overrun,     0);
    checkVal("rst_busy",  spiIf.busy,        0);
    rst_n = 1'b1;
    waitNeg(3);

    // 1: legal frame, ready high, latency measured from cs_in falling
    spiIf.instr_ready = 1'b1;
    errCnt = 0; ovrCnt = 0;
    csOpen();
    checkVal("t1_busy", spiIf.busy, 1);
    shiftBits(64'hA5C3_0F81, 32);
    spiIf.cs_in = 1'b0;
    lat = 0;
    seenOut = '0;
    // First negedge after the sampling edge E0 gives lat=1; valid expected after E3 -> lat=4.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      lat++;
      if (spiIf.instr_valid) begin
        seenOut = spiIf.instr_out;
        break;
      end
    end
    checkVal("t1_latency", lat, 4);
    checkVal("t1_out", seenOut, 32'hA5C3_0F81);
    @(negedge clk);
    checkVal("t1_valid_one_cycle", spiIf.instr_valid, 0);
    waitNeg(4);
    checkVal("t1_err", errCnt, 0);
    checkVal("t1_ovr", ovrCnt, 0);
    checkVal("t1_busy_end", spiIf.busy, 0);

    // 2: short (31) and long (33) frames
    errCnt = 0;
    sendFrame(64'h1234_5678, 31);
    checkVal("t2_short_err", errCnt, 1);
    checkVal("t2_short_valid", spiIf.instr_valid, 0);
    sendFrame(64'h1_FFFF_0000, 33);
    checkVal("t2_long_err", errCnt, 2);
    checkVal("t2_long_valid", spiIf.instr_valid, 0);

    // 3: word held with ready low, second frame overruns
    spiIf.instr_ready = 1'b0;
    errCnt = 0; ovrCnt = 0;
    sendFrame(64'h1111_1111, 32);
    checkVal("t3_valid", spiIf.instr_valid, 1);
    checkVal("t3_out1", spiIf.instr_out, 32'h1111_1111);
    sendFrame(64'h2222_2222, 32);
    checkVal("t3_ovr", ovrCnt, 1);
    checkVal("t3_out_held", spiIf.instr_out, 32'h1111_1111);
    checkVal("t3_valid_held", spiIf.instr_valid, 1);
    spiIf.instr_ready = 1'b1;
    @(negedge clk);
    spiIf.instr_ready = 1'b0;
    checkVal("t3_consumed", spiIf.instr_valid, 0);
    checkVal("t3_err", errCnt, 0);

    // 4: ready asserted on the very edge a second legal frame completes
    ovrCnt = 0;
    sendFrame(64'h1234_5678, 32);
    checkVal("t4_first", spiIf.instr_out, 32'h1234_5678);
    csOpen();
    shiftBits(64'h3333_3333, 32);
    spiIf.cs_in = 1'b0;
    waitNeg(3);                 // past E0, E1, E2
    spiIf.instr_ready = 1'b1;   // high for E3 only
    @(negedge clk);
    spiIf.instr_ready = 1'b0;
    checkVal("t4_valid", spiIf.instr_valid, 1);
    checkVal("t4_out", spiIf.instr_out, 32'h3333_3333);
    waitNeg(3);
    checkVal("t4_valid_stays", spiIf.instr_valid, 1);
    checkVal("t4_ovr", ovrCnt, 0);

    // 5: reset after 16 bits of a frame while a word is still pending
    errCnt = 0; ovrCnt = 0;
    csOpen();
    shiftBits(64'hDEAD, 16);
    checkVal("t5_busy_pre", spiIf.busy, 1);
    rst_n = 1'b0;
    #1;
    checkVal("t5_rst_valid", spiIf.instr_valid, 0);
    checkVal("t5_rst_out",   spiIf.instr_out,   0);
    checkVal("t5_rst_busy",  spiIf.busy,        0);
    waitNeg(2);
    rst_n = 1'b1;
    waitNeg(4);
    csClose();                  // tail of the interrupted frame carries no bits
    sendFrame(64'hDEAD_BEEF, 32);
    checkVal("t5_valid", spiIf.instr_valid, 1);
    checkVal("t5_out", spiIf.instr_out, 32'hDEAD_BEEF);
    checkVal("t5_err", errCnt, 0);
    checkVal("t5_ovr", ovrCnt, 0);

    // 6: cs window with no sclk edges
    spiIf.instr_ready = 1'b1;
    @(negedge clk);
    spiIf.instr_ready = 1'b0;
    checkVal("t6_drained", spiIf.instr_valid, 0);
    errCnt = 0; ovrCnt = 0;
    checkVal("t6_busy_before", spiIf.busy, 0);
    csOpen();
    checkVal("t6_busy_in", spiIf.busy, 1);
    csClose();
    checkVal("t6_busy_after", spiIf.busy, 0);
    checkVal("t6_valid", spiIf.instr_valid, 0);
    checkVal("t6_err", errCnt, 0);
    checkVal("t6_ovr", ovrCnt, 0);

    checkVal("never_both_pulses", bothCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
